// File: rtl/relu_pkg.sv
// Shared definitions for the streaming activation unit: activation mode encoding
// and default geometry of the fixed-point lanes.
package relu_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LANES      = 4;
  localparam int DEF_FRAC_W     = 16;
  localparam int DEF_LEAK_SHIFT = 3;
  localparam int DEF_CLIP_INT   = 6;
  localparam int DEF_CNT_W      = 32;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_RELU  = 2'd1,
    MODE_LEAKY = 2'd2,
    MODE_CLIP  = 2'd3
  } mode_t;

endpackage

// File: rtl/relu_lane.sv
// Combinational activation of one signed fixed-point lane; also reports whether
// the input word was negative for the statistics popcount.
module relu_lane
  import relu_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FRAC_W     = DEF_FRAC_W,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int CLIP_INT   = DEF_CLIP_INT
) (
  input  logic signed [DATA_W-1:0] i_x,
  input  mode_t                    i_mode,
  output logic signed [DATA_W-1:0] o_y,
  output logic                     o_is_neg
);

  localparam logic signed [DATA_W-1:0] CLIP_VAL = DATA_W'(CLIP_INT) << FRAC_W;

  // Select the activation for this lane; the sign bit drives every negative branch.
  always_comb begin
    o_is_neg = i_x[DATA_W-1];
    o_y      = i_x;
    case (i_mode)
      MODE_PASS: o_y = i_x;
      MODE_RELU: begin
        if (i_x[DATA_W-1]) o_y = {DATA_W{1'b0}};
        else               o_y = i_x;
      end
      MODE_LEAKY: begin
        if (i_x[DATA_W-1]) o_y = i_x >>> LEAK_SHIFT;
        else               o_y = i_x;
      end
      MODE_CLIP: begin
        if (i_x[DATA_W-1])      o_y = {DATA_W{1'b0}};
        else if (i_x > CLIP_VAL) o_y = CLIP_VAL;
        else                     o_y = i_x;
      end
      default: o_y = i_x;
    endcase
  end

endmodule

// File: rtl/relu_stream_unit.sv
// Multi-lane streaming activation unit: two-stage elastic pipeline with a per-beat
// activation mode and a saturating count of delivered negative lanes.
module relu_stream_unit
  import relu_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LANES      = DEF_LANES,
  parameter int FRAC_W     = DEF_FRAC_W,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int CLIP_INT   = DEF_CLIP_INT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                Mode_In,
  input  logic [LANES*DATA_W-1:0]   Data_In,
  input  logic                      Valid_In,
  output logic                      In_Ready,
  output logic [LANES*DATA_W-1:0]   Data_Out,
  output logic                      Valid_Out,
  input  logic                      Out_Ready,
  input  logic                      Clear_Stats,
  output logic [CNT_W-1:0]          Neg_Count
);

  localparam int BUS_W = LANES * DATA_W;
  localparam int POP_W = $clog2(LANES + 1);

  logic             r_s1_valid;
  logic [BUS_W-1:0] r_s1_data;
  mode_t            r_s1_mode;
  logic             r_s2_valid;
  logic [BUS_W-1:0] r_s2_data;
  logic [POP_W-1:0] r_s2_pop;
  logic [CNT_W-1:0] r_neg_count;

  logic             w_s2_load;
  logic             w_s1_load;
  logic             w_accept;
  logic             w_deliver;
  logic [BUS_W-1:0] w_act;
  logic [LANES-1:0] w_neg;
  logic [POP_W-1:0] w_pop;
  logic [CNT_W:0]   w_sum;

  // A stage loads when empty or when its current content moves forward this cycle.
  assign w_s2_load = !r_s2_valid || Out_Ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign In_Ready  = rst_n && w_s1_load;
  assign w_accept  = Valid_In && In_Ready;
  assign w_deliver = r_s2_valid && Out_Ready;

  // The stage-1 data register keeps each lane's sign bit, which is its negative flag.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    relu_lane #(
      .DATA_W    (DATA_W),
      .FRAC_W    (FRAC_W),
      .LEAK_SHIFT(LEAK_SHIFT),
      .CLIP_INT  (CLIP_INT)
    ) u_lane (
      .i_x     (r_s1_data[g*DATA_W +: DATA_W]),
      .i_mode  (r_s1_mode),
      .o_y     (w_act[g*DATA_W +: DATA_W]),
      .o_is_neg(w_neg[g])
    );
  end

  // Count negative lanes of the beat leaving stage 1.
  always_comb begin
    w_pop = {POP_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      w_pop = w_pop + POP_W'(w_neg[i]);
    end
  end

  assign w_sum = {1'b0, r_neg_count} + (CNT_W+1)'(r_s2_pop);

  // Stage 1: capture the accepted beat together with its mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= {BUS_W{1'b0}};
      r_s1_mode  <= MODE_PASS;
    end else if (w_s1_load) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_data <= Data_In;
        r_s1_mode <= mode_t'(Mode_In);
      end
    end
  end

  // Stage 2: hold the activated beat; data only changes when a new beat lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= {BUS_W{1'b0}};
      r_s2_pop   <= {POP_W{1'b0}};
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_act;
        r_s2_pop  <= w_pop;
      end
    end
  end

  // Saturating negative-lane statistic; a clear overrides a same-cycle delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_count <= {CNT_W{1'b0}};
    end else if (Clear_Stats) begin
      r_neg_count <= {CNT_W{1'b0}};
    end else if (w_deliver) begin
      if (w_sum[CNT_W]) r_neg_count <= {CNT_W{1'b1}};
      else              r_neg_count <= w_sum[CNT_W-1:0];
    end
  end

  assign Data_Out  = r_s2_data;
  assign Valid_Out = r_s2_valid;
  assign Neg_Count = r_neg_count;

endmodule

// File: tb/tb_relu_stream_unit.sv
// Self-checking bench for relu_stream_unit: queue-based reference model checked at
// every falling edge, plus directed beats with hand-computed results.
module tb_relu_stream_unit;

  localparam int DW   = 32;
  localparam int LN   = 4;
  localparam int BW   = DW * LN;
  localparam longint CLIP = 6 * 65536;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [1:0]    Mode_In = 2'd0;
  logic [BW-1:0] Data_In = {BW{1'b0}};
  logic          Valid_In = 1'b0;
  logic          Out_Ready = 1'b0;
  logic          Clear_Stats = 1'b0;
  logic          In_Ready, Valid_Out, In_Ready4, Valid_Out4;
  logic [BW-1:0] Data_Out, Data_Out4;
  logic [31:0]   Neg_Count;
  logic [3:0]    Neg_Count4;

  relu_stream_unit dut (
    .clk(clk), .rst_n(rst_n), .Mode_In(Mode_In), .Data_In(Data_In), .Valid_In(Valid_In),
    .In_Ready(In_Ready), .Data_Out(Data_Out), .Valid_Out(Valid_Out), .Out_Ready(Out_Ready),
    .Clear_Stats(Clear_Stats), .Neg_Count(Neg_Count)
  );

  relu_stream_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .Mode_In(Mode_In), .Data_In(Data_In), .Valid_In(Valid_In),
    .In_Ready(In_Ready4), .Data_Out(Data_Out4), .Valid_Out(Valid_Out4), .Out_Ready(Out_Ready),
    .Clear_Stats(Clear_Stats), .Neg_Count(Neg_Count4)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic longint act_lane(input longint x, input int m);
    case (m)
      0: return x;
      1: return (x < 0) ? 0 : x;
      2: return (x < 0) ? (x - 7) / 8 : x;   // floor division by 8
      3: return (x < 0) ? 0 : ((x > CLIP) ? CLIP : x);
      default: return x;
    endcase
  endfunction

  function automatic logic [BW-1:0] model_beat(input logic [BW-1:0] d, input logic [1:0] m);
    logic [BW-1:0] r;
    for (int i = 0; i < LN; i++) begin
      longint x;
      x = longint'($signed(d[i*DW +: DW]));
      r[i*DW +: DW] = 32'(act_lane(x, int'(m)));
    end
    return r;
  endfunction

  function automatic int neg_lanes(input logic [BW-1:0] d);
    int n = 0;
    for (int i = 0; i < LN; i++) if ($signed(d[i*DW +: DW]) < 0) n++;
    return n;
  endfunction

  function automatic logic [BW-1:0] pack4(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  function automatic logic [31:0] rand_lane();
    case ($urandom % 4)
      0: return $urandom;
      1: return 32'($signed(int'($urandom_range(0, 40)) - 20));
      2: return 32'h0006_0000 + 32'($urandom_range(0, 4)) - 32'd2;
      default: return 32'h8000_0000 | 32'($urandom);
    endcase
  endfunction

  function automatic logic [BW-1:0] rand_beat();
    return {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
  endfunction

  typedef struct { logic [BW-1:0] d; int pop; } beat_t;
  beat_t  q[$];
  longint cnt = 0, cnt4 = 0;
  logic   prev_stall = 1'b0;
  logic [BW-1:0] prev_data = {BW{1'b0}};

  // Compare process: check outputs, then advance the model across the coming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      cnt = 0; cnt4 = 0; prev_stall = 1'b0;
      check("rst_valid_out", BW'(Valid_Out), BW'(1'b0));
      check("rst_neg_count", BW'(Neg_Count), BW'(0));
      check("rst_in_ready", BW'(In_Ready), BW'(1'b0));
    end else begin
      check("neg_count", BW'(Neg_Count), BW'(cnt));
      check("neg_count_w4", BW'(Neg_Count4), BW'(cnt4));
      if (prev_stall) begin
        check("stall_valid", BW'(Valid_Out), BW'(1'b1));
        check("stall_hold", Data_Out, prev_data);
      end
      if (Valid_Out) begin
        check("beat_expected", BW'(q.size() != 0), BW'(1'b1));
        if (q.size() != 0) check("data_out", Data_Out, q[0].d);
      end
      if (Valid_Out4 && q.size() != 0) check("data_out_w4", Data_Out4, q[0].d);
      if (Valid_Out && Out_Ready && q.size() != 0) begin
        beat_t b;
        b = q.pop_front();
        cnt  = (cnt + b.pop > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : cnt + b.pop;
        cnt4 = (cnt4 + b.pop > 15) ? 15 : cnt4 + b.pop;
      end
      if (Clear_Stats) begin
        cnt = 0; cnt4 = 0;
      end
      if (Valid_In && In_Ready) begin
        beat_t nb;
        nb.d = model_beat(Data_In, Mode_In);
        nb.pop = neg_lanes(Data_In);
        q.push_back(nb);
      end
      prev_stall = Valid_Out && !Out_Ready;
      prev_data  = Data_Out;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic put(input logic [1:0] m, input logic [BW-1:0] d);
    logic got = 1'b0;
    Valid_In = 1'b1; Mode_In = m; Data_In = d;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (In_Ready) got = 1'b1;
      @(posedge clk); #1;
    end
    check("accept_timeout", BW'(got), BW'(1'b1));
  endtask

  task automatic idle();
    Valid_In = 1'b0; Mode_In = 2'($urandom); Data_In = rand_beat();
  endtask

  task automatic drain();
    Out_Ready = 1'b1;
    for (int t = 0; t < 100 && (q.size() != 0 || Valid_Out); t++) begin
      @(posedge clk); #2;
    end
    check("drain_empty", BW'(q.size()), BW'(0));
  endtask

  // Empty pipeline, Out_Ready high: result must appear on the second falling edge.
  task automatic direct(input string name, input logic [1:0] m, input logic [BW-1:0] d,
                        input logic [BW-1:0] exp, input int exp_cnt);
    Out_Ready = 1'b1;
    put(m, d);
    idle();
    @(negedge clk);
    check({name, "_not_early"}, BW'(Valid_Out), BW'(1'b0));
    @(negedge clk);
    check({name, "_valid"}, BW'(Valid_Out), BW'(1'b1));
    check({name, "_data"}, Data_Out, exp);
    @(posedge clk); #1;
    check({name, "_count"}, BW'(Neg_Count), BW'(exp_cnt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    time t0;
    check("pin_relu", model_beat(pack4(-5, 0, 7, 32'h7FFF_FFFF), 2'd1), pack4(0, 0, 7, 32'h7FFF_FFFF));
    check("pin_leaky", model_beat(pack4(-8, -1, -9, 16), 2'd2), pack4(-1, -1, -2, 16));
    check("pin_clip", model_beat(pack4(32'h0007_0000, 32'h0006_0000, 32'h0005_8000, -1), 2'd3),
          pack4(32'h0006_0000, 32'h0006_0000, 32'h0005_8000, 0));

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    direct("relu", 2'd1, pack4(-5, 0, 7, 32'h7FFF_FFFF), pack4(0, 0, 7, 32'h7FFF_FFFF), 1);
    direct("leaky", 2'd2, pack4(-8, -1, -9, 16), pack4(-1, -1, -2, 16), 4);
    direct("clip", 2'd3, pack4(32'h0007_0000, 32'h0006_0000, 32'h0005_8000, -1),
           pack4(32'h0006_0000, 32'h0006_0000, 32'h0005_8000, 0), 5);

    // Back-to-back burst of all-negative beats: full throughput and saturation.
    Clear_Stats = 1'b1; @(posedge clk); #1 Clear_Stats = 1'b0;
    t0 = $time;
    for (int i = 0; i < 5; i++) put(2'd0, {BW{1'b1}});
    check("throughput_cycles", BW'(($time - t0) / 10), BW'(5));
    idle();
    drain();
    check("sat_count_w4", BW'(Neg_Count4), BW'(15));
    check("count_w32", BW'(Neg_Count), BW'(20));

    // Clear concurrent with a delivery handshake.
    Out_Ready = 1'b0;
    put(2'd1, {BW{1'b1}});
    idle();
    for (int t = 0; t < 10 && !Valid_Out; t++) begin @(posedge clk); #1; end
    Clear_Stats = 1'b1; Out_Ready = 1'b1;
    @(posedge clk); #1;
    Clear_Stats = 1'b0;
    check("clear_wins", BW'(Neg_Count), BW'(0));
    check("clear_wins_w4", BW'(Neg_Count4), BW'(0));

    // Random burst with 50% back-pressure.
    for (int c = 0; c < 300; c++) begin
      Out_Ready = 1'($urandom);
      if (($urandom % 4) != 0) begin
        Valid_In = 1'b1; Mode_In = 2'($urandom); Data_In = rand_beat();
      end else begin
        idle();
      end
      @(posedge clk); #1;
    end
    idle();
    drain();

    // Reset with two beats in flight.
    Out_Ready = 1'b0;
    put(2'd0, {BW{1'b1}});
    put(2'd1, rand_beat());
    idle();
    rst_n = 1'b0;
    #1;
    check("midrst_valid_out", BW'(Valid_Out), BW'(1'b0));
    check("midrst_neg_count", BW'(Neg_Count), BW'(0));
    check("midrst_in_ready", BW'(In_Ready), BW'(1'b0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", BW'(In_Ready), BW'(1'b1));
    Out_Ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale_beat", BW'(Valid_Out), BW'(1'b0));
    end

    // A short random tail after reset.
    for (int c = 0; c < 60; c++) begin
      Out_Ready = 1'($urandom);
      Valid_In = 1'($urandom); Mode_In = 2'($urandom); Data_In = rand_beat();
      @(posedge clk); #1;
    end
    idle();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
